// File: rtl/imm_ext_pkg.sv
// Shared constants for the pipelined immediate extender.
// The mode encodings match the 2-bit in_mode field used in decode.
package imm_ext_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_ZERO  = 2'd0;
  localparam logic [MODE_W-1:0] MODE_SIGN  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_SHL1  = 2'd2;
  localparam logic [MODE_W-1:0] MODE_UPPER = 2'd3;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate widening: zero, sign, sign+shift-left-1 and upper placement.
// Only the selected result is forwarded; all four are cheap enough to build in parallel.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]   in_imm,
  input  logic [MODE_W-1:0] in_mode,
  output logic [OUT_W-1:0]  out_data
);

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] shl1;
  logic [OUT_W-1:0] upper;

  assign zext = {{(OUT_W-IN_W){1'b0}}, in_imm};

  assign sext[IN_W-1:0] = in_imm;
  for (genvar gi = IN_W; gi < OUT_W; gi++) begin : g_sign_fill
    assign sext[gi] = in_imm[IN_W-1];
  end

  // Shifting the sign-extended value keeps this legal even when OUT_W == IN_W+1.
  assign shl1  = {sext[OUT_W-2:0], 1'b0};
  assign upper = {in_imm, {(OUT_W-IN_W){1'b0}}};

  always_comb begin
    out_data = zext;
    case (in_mode)
      MODE_ZERO:  out_data = zext;
      MODE_SIGN:  out_data = sext;
      MODE_SHL1:  out_data = shl1;
      MODE_UPPER: out_data = upper;
      default:    out_data = zext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender followed by a 2-entry in-order skid buffer with valid/ready on both sides.
// The head entry register drives the outputs directly, so out_data/out_tag are glitch-free.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_imm,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag
);

  logic [1:0]       count_q, count_d;
  logic [OUT_W-1:0] head_data_q, head_data_d;
  logic [TAG_W-1:0] head_tag_q, head_tag_d;
  logic [OUT_W-1:0] tail_data_q, tail_data_d;
  logic [TAG_W-1:0] tail_tag_q, tail_tag_d;
  logic [OUT_W-1:0] ext_data;
  logic             push;
  logic             pop;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_imm   (in_imm),
    .in_mode  (in_mode),
    .out_data (ext_data)
  );

  assign in_ready  = (count_q != 2'd2) && !rst;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_data_q;
  assign out_tag   = head_tag_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d     = count_q;
    head_data_d = head_data_q;
    head_tag_d  = head_tag_q;
    tail_data_d = tail_data_q;
    tail_tag_d  = tail_tag_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_data_d = ext_data;
          head_tag_d  = in_tag;
          count_d     = 2'd1;
        end
      end
      2'd1: begin
        // With a simultaneous pop the new beat becomes the head straight away.
        if (push && pop) begin
          head_data_d = ext_data;
          head_tag_d  = in_tag;
        end else if (push) begin
          tail_data_d = ext_data;
          tail_tag_d  = in_tag;
          count_d     = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_data_d = tail_data_q;
          head_tag_d  = tail_tag_q;
          count_d     = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= 2'd0;
      head_data_q <= '0;
      head_tag_q  <= '0;
      tail_data_q <= '0;
      tail_tag_q  <= '0;
    end else begin
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_tag_q  <= head_tag_d;
      tail_data_q <= tail_data_d;
      tail_tag_q  <= tail_tag_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench: a queue-based reference of the 2-entry buffer plus arithmetic extension model.
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_imm;
  logic [1:0]  in_mode;
  logic [3:0]  in_tag, out_tag;
  logic [15:0] out_data;

  logic        in2_valid, in2_ready, out2_valid, out2_ready;
  logic [11:0] in2_imm;
  logic [1:0]  in2_mode;
  logic [3:0]  in2_tag, out2_tag;
  logic [31:0] out2_data;

  imm_extend_pipe #(.IN_W(8), .OUT_W(16), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(32), .TAG_W(4)) dut_wide (
    .clk(clk), .rst(rst),
    .in_valid(in2_valid), .in_ready(in2_ready), .in_imm(in2_imm), .in_mode(in2_mode), .in_tag(in2_tag),
    .out_valid(out2_valid), .out_ready(out2_ready), .out_data(out2_data), .out_tag(out2_tag)
  );

  typedef struct {
    logic [15:0] data;
    logic [3:0]  tag;
  } beat_t;

  beat_t q[$];
  beat_t pend;
  int    n_assert = 0;
  int    n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Reference extension written directly from the arithmetic meaning of each mode.
  function automatic logic [15:0] ref_ext(input logic [7:0] imm, input logic [1:0] mode);
    longint u = longint'(imm);
    longint s = (imm >= 8'd128) ? u - 256 : u;
    longint r;
    case (mode)
      2'd0:    r = u;
      2'd1:    r = s;
      2'd2:    r = s * 2;
      default: r = u * 256;
    endcase
    return 16'(r & 64'hFFFF);
  endfunction

  task automatic drive(input logic [7:0] imm, input logic [1:0] mode, input logic [3:0] tag,
                       input logic [15:0] exp);
    in_valid  = 1'b1;
    in_imm    = imm;
    in_mode   = mode;
    in_tag    = tag;
    pend.data = exp;
    pend.tag  = tag;
  endtask

  // Checks the outputs against the queue model, then advances one clock and updates the model.
  task automatic cycle(output bit accepted);
    bit exp_ready, do_pop, do_push;
    #1;
    exp_ready = (q.size() < 2) && !rst;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_data", 32'(out_data), 32'(q[0].data));
      chk("out_tag", 32'(out_tag), 32'(q[0].tag));
    end
    do_pop   = (q.size() != 0) && out_ready;
    do_push  = in_valid && exp_ready;
    accepted = do_push;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
    end else begin
      if (do_pop) begin
        $display("t=%0t pop  data=%h tag=%0d", $time, q[0].data, q[0].tag);
        void'(q.pop_front());
      end
      if (do_push) begin
        $display("t=%0t push data=%h tag=%0d", $time, pend.data, pend.tag);
        q.push_back(pend);
      end
    end
  endtask

  initial begin
    bit acc;
    logic [7:0] r_imm;
    logic [1:0] r_mode;
    logic [7:0] d_imm;
    logic [1:0] d_mode;

    rst = 1'b1; in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0; out_ready = 1'b0;
    in2_valid = 1'b0; in2_imm = '0; in2_mode = '0; in2_tag = '0; out2_ready = 1'b1;
    @(posedge clk); #1;
    cycle(acc);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_tag", 32'(out_tag), 32'h0);
    rst = 1'b0;

    // Directed mode sweep on 8'hA5 with a draining consumer.
    out_ready = 1'b1;
    drive(8'hA5, 2'd0, 4'd1, 16'h00A5); cycle(acc);
    drive(8'hA5, 2'd1, 4'd2, 16'hFFA5); cycle(acc);
    drive(8'hA5, 2'd2, 4'd3, 16'hFF4A); cycle(acc);
    drive(8'hA5, 2'd3, 4'd4, 16'hA500); cycle(acc);
    drive(8'h7F, 2'd1, 4'd5, 16'h007F); cycle(acc);
    drive(8'h7F, 2'd2, 4'd6, 16'h00FE); cycle(acc);
    drive(8'h80, 2'd2, 4'd7, 16'hFF00); cycle(acc);
    in_valid = 1'b0;
    cycle(acc); cycle(acc);

    // Fill the buffer under stall; tag 3 is held until it is taken.
    out_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      drive(8'(t), 2'd0, 4'(t), 16'(t));
      do cycle(acc); while (!acc && t < 3);
    end
    chk("full_in_ready", 32'(in_ready), 32'h0);
    cycle(acc);
    out_ready = 1'b1;
    do cycle(acc); while (!acc);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle(acc);

    // Streaming with out_ready toggling every cycle.
    for (int i = 0; i < 40; i++) begin
      d_imm  = 8'($urandom);
      d_mode = 2'($urandom);
      drive(d_imm, d_mode, 4'($urandom), ref_ext(d_imm, d_mode));
      out_ready = i[0];
      cycle(acc);
    end
    // Fully random valid/ready.
    for (int i = 0; i < 60; i++) begin
      r_imm  = 8'($urandom);
      r_mode = 2'($urandom_range(3, 0));
      if ($urandom_range(3, 0) != 0) drive(r_imm, r_mode, 4'($urandom), ref_ext(r_imm, r_mode));
      else in_valid = 1'b0;
      out_ready = ($urandom_range(2, 0) != 0);
      cycle(acc);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle(acc);

    // Reset while holding two beats.
    out_ready = 1'b0;
    drive(8'h11, 2'd0, 4'hA, 16'h0011); cycle(acc);
    drive(8'h22, 2'd0, 4'hB, 16'h0022); cycle(acc);
    rst = 1'b1;
    drive(8'h33, 2'd0, 4'hC, 16'h0033);
    cycle(acc);
    rst = 1'b0; in_valid = 1'b0;
    chk("post_rst_out_data", 32'(out_data), 32'h0);
    chk("post_rst_out_tag", 32'(out_tag), 32'h0);
    out_ready = 1'b1;
    drive(8'h44, 2'd1, 4'hD, 16'h0044); cycle(acc);
    in_valid = 1'b0;
    cycle(acc); cycle(acc);

    // Wide instance: IN_W=12, OUT_W=32.
    in2_valid = 1'b1; in2_imm = 12'h800; in2_mode = 2'd1; in2_tag = 4'd1;
    @(posedge clk); #1;
    chk("wide_sign_valid", 32'(out2_valid), 32'h1);
    chk("wide_sign", out2_data, 32'hFFFFF800);
    in2_mode = 2'd3; in2_tag = 4'd2;
    @(posedge clk); #1;
    chk("wide_upper", out2_data, 32'h80000000);
    chk("wide_upper_tag", 32'(out2_tag), 32'h2);
    in2_mode = 2'd0; in2_tag = 4'd3;
    @(posedge clk); #1;
    chk("wide_zero", out2_data, 32'h00000800);
    in2_valid = 1'b0;
    @(posedge clk); #1;
    chk("wide_drained", 32'(out2_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
